bram_bank_arbiter: RTL and testbench
====================================

Name: bram_bank_arbiter

Overview:
- Shares the four 1024x64 on-chip BRAM banks of the camera memory subsystem between two requesters.
- Master 0 is the camera pixel packer/writer; master 1 is the filter/VGA reader. Either master may read or write.
- A global 12-bit word address selects the bank and the word within it. Requests to different banks are granted in the same cycle; requests to the same bank are arbitrated.
- Read data is returned with a valid strobe after a fixed latency. A saturating counter records bank conflicts.

Parameters:
- DATA_W, 64, data width per bank word.
- WORD_AW, 10, word address width inside one bank.
- READ_LAT, 1, BRAM read latency in cycles; legal values are 1 and 2.
- ARB_MODE, 0, conflict policy: 0 = round-robin, 1 = master 0 fixed priority.

Ports:
- iCLK  in  1  system clock (CLOCK_50 domain).
- iRST  in  1  synchronous reset, active-high.
- iM0_REQ  in  1  master 0 request; held with its attributes until granted.
- iM0_WE  in  1  master 0 operation: 1 = write, 0 = read.
- iM0_ADDR  in  WORD_AW+2  master 0 address; [WORD_AW+1:WORD_AW] = bank, [WORD_AW-1:0] = word.
- iM0_WDATA  in  DATA_W  master 0 write data.
- iM0_BE  in  DATA_W/8  master 0 byte enables.
- oM0_GNT  out  1  master 0 grant; the request is accepted in this cycle.
- oM0_RDATA  out  DATA_W  master 0 read data.
- oM0_RVALID  out  1  master 0 read data valid.
- iM1_REQ, iM1_WE, iM1_ADDR, iM1_WDATA, iM1_BE, oM1_GNT, oM1_RDATA, oM1_RVALID: same widths and meanings, for master 1.
- oBANK_CS  out  4  per-bank chipselect.
- oBANK_CLKEN  out  4  per-bank clock enable; constant 4'b1111.
- oBANK_WRITE  out  4  per-bank write strobe.
- oBANK_ADDR  out  4*WORD_AW  bank n address at [n*WORD_AW +: WORD_AW].
- oBANK_WDATA  out  4*DATA_W  bank n write data, packed the same way.
- oBANK_BE  out  4*DATA_W/8  bank n byte enables, packed the same way.
- iBANK_RDATA  in  4*DATA_W  bank n read data, packed the same way.
- oCONFLICT_CNT  out  16  number of same-bank conflicts; saturates at 16'hFFFF.

Behaviour:
- Handshake:
  - A request is accepted in the cycle where REQ=1 and GNT=1.
  - GNT is combinational from REQ, the bank fields and the priority state. It never asserts without REQ.
  - A master must hold REQ, WE, ADDR, WDATA and BE stable until granted. Deasserting REQ before the grant is allowed and simply withdraws the request.
- Bank drive:
  - In a grant cycle, the winning master's word address, write data, byte enables and write strobe are driven combinationally onto its bank. That bank's CS is 1.
  - An unselected bank gets CS=0 and WRITE=0; its address, data and BE are don't-care, driven 0.
- Different banks: both masters are granted in the same cycle.
- Same bank (a conflict):
  - ARB_MODE=0: the master indicated by the priority pointer prr wins. After a conflict, prr points to the loser.
  - prr changes only on conflict cycles.
  - ARB_MODE=1: master 0 always wins.
  - The loser's GNT=0. Each conflict cycle increments oCONFLICT_CNT by 1, saturating.
- Writes: complete at the grant edge. No RVALID is produced for a write.
- Reads:
  - For each master, a READ_LAT-deep shift register carries {valid, bank}.
  - oMx_RVALID asserts exactly READ_LAT cycles after the read's grant cycle, for one cycle.
  - oMx_RDATA is iBANK_RDATA of the recorded bank, muxed combinationally in the RVALID cycle. When RVALID=0, RDATA is 0.
  - Back-to-back grants give back-to-back RVALIDs, in order.
- Simultaneous read and write to the same bank and word: this is a conflict, resolved by arbitration. The loser sees the winner's effect; the read returns old data only if the read wins.
- Reset (iRST=1 at a rising edge):
  - The following clear: both shift registers (RVALID=0), prr = master 0, oCONFLICT_CNT = 0.
  - While iRST=1: GNT=0 for both masters, CS=0, WRITE=0, RVALID=0, RDATA=0.
  - Reads in flight when reset asserts are dropped and never return RVALID.
- Address width: there is no truncation. The bank is always ADDR[WORD_AW+1:WORD_AW], so every address maps to exactly one bank.

Test Plan:
1. Different banks: M0 writes 12'h005 (bank 0, word 5) with 64'hDEADBEEF_00000001, BE=8'hFF, while M1 reads 12'h405 (bank 1), same cycle. Required: both GNT=1; oBANK_WRITE=4'b0001; oBANK_CS=4'b0011; M1 RVALID one cycle later (READ_LAT=1) carrying bank 1 data; counter=0.
2. Round-robin conflict: both masters hold requests to bank 2 for 4 cycles. Required: grants alternate M0, M1, M0, M1; oCONFLICT_CNT=4.
3. Fixed priority: ARB_MODE=1, both masters request bank 3 for 3 cycles. Required: M0 granted all 3 cycles; M1 GNT=0 throughout; counter=3.
4. Read-after-write: M0 writes 12'h7FF = 64'h0123456789ABCDEF with BE=8'h0F. Next cycle M0 reads 12'h7FF. Required: RVALID with data whose low 4 bytes are 89ABCDEF and whose upper bytes are unchanged. Repeat with READ_LAT=2: RVALID arrives 2 cycles after the grant.
5. Reset mid-read: M1 read granted, then iRST=1 on the next edge. Required: no RVALID appears; after reset, counter=0 and prr=M0, so the first conflict grants M0.
6. Saturation: force 65537 conflicts. Required: oCONFLICT_CNT stays at 16'hFFFF.

Source files
------------

// File: rtl/bram_bank_arbiter.sv
// rtl/bram_bank_arbiter.sv - two-master arbiter for four on-chip BRAM banks
module bram_bank_arbiter #(
  parameter int DATA_W   = 64,
  parameter int WORD_AW  = 10,
  parameter int READ_LAT = 1,
  parameter int ARB_MODE = 0
) (
  input  logic                      iCLK,
  input  logic                      iRST,
  input  logic                      iM0_REQ,
  input  logic                      iM0_WE,
  input  logic [WORD_AW+1:0]        iM0_ADDR,
  input  logic [DATA_W-1:0]         iM0_WDATA,
  input  logic [DATA_W/8-1:0]       iM0_BE,
  output logic                      oM0_GNT,
  output logic [DATA_W-1:0]         oM0_RDATA,
  output logic                      oM0_RVALID,
  input  logic                      iM1_REQ,
  input  logic                      iM1_WE,
  input  logic [WORD_AW+1:0]        iM1_ADDR,
  input  logic [DATA_W-1:0]         iM1_WDATA,
  input  logic [DATA_W/8-1:0]       iM1_BE,
  output logic                      oM1_GNT,
  output logic [DATA_W-1:0]         oM1_RDATA,
  output logic                      oM1_RVALID,
  output logic [3:0]                oBANK_CS,
  output logic [3:0]                oBANK_CLKEN,
  output logic [3:0]                oBANK_WRITE,
  output logic [4*WORD_AW-1:0]      oBANK_ADDR,
  output logic [4*DATA_W-1:0]       oBANK_WDATA,
  output logic [4*(DATA_W/8)-1:0]   oBANK_BE,
  input  logic [4*DATA_W-1:0]       iBANK_RDATA,
  output logic [15:0]               oCONFLICT_CNT
);
  localparam int BE_W = DATA_W / 8;

  logic [1:0] m0_bank, m1_bank;
  logic       conflict, m0_wins, prr;
  logic       m0_rd_fire, m1_rd_fire;
  logic [READ_LAT-1:0] m0_v, m1_v;
  logic [1:0]          m0_bk [READ_LAT];
  logic [1:0]          m1_bk [READ_LAT];

  assign m0_bank = iM0_ADDR[WORD_AW+1:WORD_AW];
  assign m1_bank = iM1_ADDR[WORD_AW+1:WORD_AW];

  // prr=0 favours master 0; it is only consulted in round-robin mode
  assign conflict = !iRST && iM0_REQ && iM1_REQ && (m0_bank == m1_bank);
  assign m0_wins  = (ARB_MODE == 1) || !prr;
  assign oM0_GNT  = !iRST && iM0_REQ && (!conflict || m0_wins);
  assign oM1_GNT  = !iRST && iM1_REQ && (!conflict || !m0_wins);

  assign m0_rd_fire  = oM0_GNT && !iM0_WE;
  assign m1_rd_fire  = oM1_GNT && !iM1_WE;
  assign oBANK_CLKEN = 4'b1111;

  always_comb begin
    oBANK_CS    = '0;
    oBANK_WRITE = '0;
    oBANK_ADDR  = '0;
    oBANK_WDATA = '0;
    oBANK_BE    = '0;
    for (int n = 0; n < 4; n++) begin
      if (oM0_GNT && m0_bank == 2'(n)) begin
        oBANK_CS[n]                       = 1'b1;
        oBANK_WRITE[n]                    = iM0_WE;
        oBANK_ADDR[n*WORD_AW +: WORD_AW]  = iM0_ADDR[WORD_AW-1:0];
        oBANK_WDATA[n*DATA_W +: DATA_W]   = iM0_WDATA;
        oBANK_BE[n*BE_W +: BE_W]          = iM0_BE;
      end else if (oM1_GNT && m1_bank == 2'(n)) begin
        oBANK_CS[n]                       = 1'b1;
        oBANK_WRITE[n]                    = iM1_WE;
        oBANK_ADDR[n*WORD_AW +: WORD_AW]  = iM1_ADDR[WORD_AW-1:0];
        oBANK_WDATA[n*DATA_W +: DATA_W]   = iM1_WDATA;
        oBANK_BE[n*BE_W +: BE_W]          = iM1_BE;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      prr           <= 1'b0;
      oCONFLICT_CNT <= '0;
      m0_v          <= '0;
      m1_v          <= '0;
    end else begin
      if (conflict) begin
        prr <= m0_wins;
        if (oCONFLICT_CNT != 16'hFFFF)
          oCONFLICT_CNT <= oCONFLICT_CNT + 16'd1;
      end
      m0_v[0] <= m0_rd_fire;
      m1_v[0] <= m1_rd_fire;
      for (int i = 1; i < READ_LAT; i++) begin
        m0_v[i] <= m0_v[i-1];
        m1_v[i] <= m1_v[i-1];
      end
    end
  end

  // bank tags need no reset: they are only looked at behind the valid bits
  always_ff @(posedge iCLK) begin
    m0_bk[0] <= m0_bank;
    m1_bk[0] <= m1_bank;
    for (int i = 1; i < READ_LAT; i++) begin
      m0_bk[i] <= m0_bk[i-1];
      m1_bk[i] <= m1_bk[i-1];
    end
  end

  assign oM0_RVALID = m0_v[READ_LAT-1] && !iRST;
  assign oM1_RVALID = m1_v[READ_LAT-1] && !iRST;

  always_comb begin
    oM0_RDATA = '0;
    oM1_RDATA = '0;
    for (int n = 0; n < 4; n++) begin
      if (oM0_RVALID && m0_bk[READ_LAT-1] == 2'(n))
        oM0_RDATA = iBANK_RDATA[n*DATA_W +: DATA_W];
      if (oM1_RVALID && m1_bk[READ_LAT-1] == 2'(n))
        oM1_RDATA = iBANK_RDATA[n*DATA_W +: DATA_W];
    end
  end
endmodule

// File: tb/tb_bram_bank_arbiter.sv
// tb/tb_bram_bank_arbiter.sv - directed checks for bram_bank_arbiter
module tb_bram_bank_arbiter;
  logic        clk = 1'b0;
  logic        rst, mem_init;
  logic        req0, we0, req1, we1;
  logic [11:0] addr0, addr1;
  logic [63:0] wdata0, wdata1;
  logic [7:0]  be0, be1;

  // index 0: round-robin, READ_LAT=1; index 1: fixed priority, READ_LAT=2
  logic [1:0]            gnt0, gnt1, rv0, rv1;
  logic [1:0][63:0]      rd0, rd1;
  logic [1:0][3:0]       cs, wr, clken;
  logic [1:0][39:0]      baddr;
  logic [1:0][255:0]     bwdata, brdata;
  logic [1:0][31:0]      bbe;
  logic [1:0][15:0]      cnt;

  logic [63:0]           mem [2][4][1024];
  logic [1:0][3:0][63:0] rd1q, rd2q;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  bram_bank_arbiter #(.DATA_W(64), .WORD_AW(10), .READ_LAT(1), .ARB_MODE(0)) dut_a (
    .iCLK(clk), .iRST(rst),
    .iM0_REQ(req0), .iM0_WE(we0), .iM0_ADDR(addr0), .iM0_WDATA(wdata0), .iM0_BE(be0),
    .oM0_GNT(gnt0[0]), .oM0_RDATA(rd0[0]), .oM0_RVALID(rv0[0]),
    .iM1_REQ(req1), .iM1_WE(we1), .iM1_ADDR(addr1), .iM1_WDATA(wdata1), .iM1_BE(be1),
    .oM1_GNT(gnt1[0]), .oM1_RDATA(rd1[0]), .oM1_RVALID(rv1[0]),
    .oBANK_CS(cs[0]), .oBANK_CLKEN(clken[0]), .oBANK_WRITE(wr[0]), .oBANK_ADDR(baddr[0]),
    .oBANK_WDATA(bwdata[0]), .oBANK_BE(bbe[0]), .iBANK_RDATA(brdata[0]),
    .oCONFLICT_CNT(cnt[0])
  );

  bram_bank_arbiter #(.DATA_W(64), .WORD_AW(10), .READ_LAT(2), .ARB_MODE(1)) dut_b (
    .iCLK(clk), .iRST(rst),
    .iM0_REQ(req0), .iM0_WE(we0), .iM0_ADDR(addr0), .iM0_WDATA(wdata0), .iM0_BE(be0),
    .oM0_GNT(gnt0[1]), .oM0_RDATA(rd0[1]), .oM0_RVALID(rv0[1]),
    .iM1_REQ(req1), .iM1_WE(we1), .iM1_ADDR(addr1), .iM1_WDATA(wdata1), .iM1_BE(be1),
    .oM1_GNT(gnt1[1]), .oM1_RDATA(rd1[1]), .oM1_RVALID(rv1[1]),
    .oBANK_CS(cs[1]), .oBANK_CLKEN(clken[1]), .oBANK_WRITE(wr[1]), .oBANK_ADDR(baddr[1]),
    .oBANK_WDATA(bwdata[1]), .oBANK_BE(bbe[1]), .iBANK_RDATA(brdata[1]),
    .oCONFLICT_CNT(cnt[1])
  );

  function automatic logic [63:0] init_word(input int n, input int w);
    return {8'(8'hC0 + n), 24'(w), 32'(32'h5EED_0000 + w)};
  endfunction

  // behavioural banks: one read register for dut_a, two for dut_b
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 2; k++)
        for (int n = 0; n < 4; n++)
          for (int w = 0; w < 1024; w++)
            mem[k][n][w] = init_word(n, w);
    end else begin
      for (int k = 0; k < 2; k++)
        for (int n = 0; n < 4; n++)
          if (cs[k][n]) begin
            if (wr[k][n]) begin
              for (int b = 0; b < 8; b++)
                if (bbe[k][n*8+b])
                  mem[k][n][baddr[k][n*10 +: 10]][b*8 +: 8] = bwdata[k][n*64+b*8 +: 8];
            end else begin
              rd1q[k][n] <= mem[k][n][baddr[k][n*10 +: 10]];
            end
          end
    end
    rd2q <= rd1q;
  end

  assign brdata[0] = rd1q[0];
  assign brdata[1] = rd2q[1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    logic [63:0] exp_w;
    rst = 1'b1; mem_init = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; be0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; be1 = '0;
    repeat (2) @(negedge clk);

    // reset holds everything quiet even with requests up
    req0 = 1; req1 = 1; #1;
    chk("rst_gnt0", 64'(gnt0), 64'h0);
    chk("rst_gnt1", 64'(gnt1), 64'h0);
    chk("rst_cs",   64'(cs),   64'h0);
    chk("rst_rv",   64'({rv0, rv1}), 64'h0);
    chk("rst_cnt",  64'(cnt[0]), 64'h0);
    chk("clken",    64'(clken), 64'hFF);

    // different banks: M0 writes bank 0, M1 reads bank 1
    @(negedge clk);
    rst = 0; mem_init = 0;
    req0 = 1; we0 = 1; addr0 = 12'h005; wdata0 = 64'hDEADBEEF_00000001; be0 = 8'hFF;
    req1 = 1; we1 = 0; addr1 = 12'h405; #1;
    chk("db_gnt", 64'({gnt0[0], gnt1[0]}), 64'h3);
    chk("db_write", 64'(wr[0]), 64'h1);
    chk("db_cs", 64'(cs[0]), 64'h3);
    @(negedge clk); req0 = 0; req1 = 0; #1;
    chk("db_rv1", 64'(rv1[0]), 64'h1);
    chk("db_rd1", rd1[0], init_word(1, 5));
    chk("db_rv0", 64'(rv0[0]), 64'h0);
    chk("db_cnt", 64'(cnt[0]), 64'h0);
    @(negedge clk); req1 = 1; addr1 = 12'h005; #1;
    chk("wb_gnt1", 64'(gnt1[0]), 64'h1);
    @(negedge clk); req1 = 0; #1;
    chk("wb_rd1", rd1[0], 64'hDEADBEEF_00000001);
    chk("wb_rdz0", rd0[0], 64'h0);

    // round-robin conflict on bank 2
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 12'h800;
    req1 = 1; we1 = 0; addr1 = 12'h801;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("rr_gnt0_%0d", i), 64'(gnt0[0]), 64'((i % 2) == 0));
      chk($sformatf("rr_gnt1_%0d", i), 64'(gnt1[0]), 64'((i % 2) == 1));
    end
    @(negedge clk); req0 = 0; req1 = 0; #1;
    chk("rr_cnt", 64'(cnt[0]), 64'd4);

    // fixed priority conflict on bank 3
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    req0 = 1; addr0 = 12'hC00;
    req1 = 1; addr1 = 12'hC10;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk($sformatf("fp_gnt_%0d", i), 64'({gnt0[1], gnt1[1]}), 64'h2);
    end
    @(negedge clk); req0 = 0; req1 = 0; #1;
    chk("fp_cnt", 64'(cnt[1]), 64'd3);

    // partial write then read of the top word of bank 1
    exp_w = init_word(1, 10'h3FF);
    exp_w = {exp_w[63:32], 32'h89ABCDEF};
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 12'h7FF; wdata0 = 64'h01234567_89ABCDEF; be0 = 8'h0F; #1;
    chk("raw_wgnt", 64'(gnt0), 64'h3);
    @(negedge clk); we0 = 0; #1;
    chk("raw_rgnt", 64'(gnt0), 64'h3);
    @(negedge clk); req0 = 0; #1;
    chk("raw_rv_l1", 64'(rv0[0]), 64'h1);
    chk("raw_rd_l1", rd0[0], exp_w);
    chk("raw_rv_l2_early", 64'(rv0[1]), 64'h0);
    @(negedge clk); #1;
    chk("raw_rv_l2", 64'(rv0[1]), 64'h1);
    chk("raw_rd_l2", rd0[1], exp_w);
    chk("raw_rv_l1_once", 64'(rv0[0]), 64'h0);

    // reset while a read is in flight
    @(negedge clk); req1 = 1; we1 = 0; addr1 = 12'h405; #1;
    chk("mr_gnt1", 64'(gnt1), 64'h3);
    @(negedge clk); rst = 1; req1 = 0; #1;
    chk("mr_rv_in_rst", 64'(rv1), 64'h0);
    @(negedge clk); rst = 0; #1;
    chk("mr_rv_after", 64'(rv1), 64'h0);
    @(negedge clk); #1;
    chk("mr_rv_late", 64'(rv1), 64'h0);
    chk("mr_cnt", 64'(cnt[0]), 64'h0);
    req0 = 1; we0 = 0; addr0 = 12'h010;
    req1 = 1; we1 = 0; addr1 = 12'h020; #1;
    chk("mr_prr", 64'({gnt0[0], gnt1[0]}), 64'h2);

    // saturation of the conflict counter
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    repeat (65534) @(negedge clk);
    #1;
    chk("sat_fffe", 64'(cnt[0]), 64'hFFFE);
    @(negedge clk); #1;
    chk("sat_ffff", 64'(cnt[0]), 64'hFFFF);
    repeat (2) @(negedge clk);
    #1;
    chk("sat_hold_a", 64'(cnt[0]), 64'hFFFF);
    chk("sat_hold_b", 64'(cnt[1]), 64'hFFFF);
    req0 = 0; req1 = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
